// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4 burst master: FSM state encoding,
// fixed AXI4 sideband values and the AxSIZE helper.
package axi_pkg;

  // Transaction sequencer states. S_BNDERR is only reachable when
  // AXI_4K_CHECK_EN is defined (4KB-crossing requests are refused).
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WADDR  = 3'd1,
    S_WDATA  = 3'd2,
    S_WRESP  = 3'd3,
    S_RADDR  = 3'd4,
    S_RDATA  = 3'd5,
    S_BNDERR = 3'd6
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AxSIZE encodes bytes per beat as log2(bytes).
  function automatic logic [2:0] axsize(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter with last-beat compare, shared by the write-data and
// read-data phases. Counts accepted beats; last_o flags beat index == len.
module axi_beat_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [7:0] len_i,
  output logic [7:0] cnt_o,
  output logic       last_o
);

  logic [7:0] cnt_q;

  // Full 8-bit count so len=255 compares before any wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 burst master: turns a request/stream interface into single
// outstanding AXI4 INCR bursts of 1..MAX_BEATS beats.
// Optional feature macro: AXI_4K_CHECK_EN -- refuse requests that would
// cross a 4KB boundary (DONE with ERR=1, no AXI traffic).
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                CLK,
  input  logic                RST,
  // request side
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WE,
  input  logic [ADDR_W-1:0]   REQ_ADDR,
  input  logic [7:0]          REQ_LEN,
  // write-data stream
  input  logic                WD_VALID,
  output logic                WD_READY,
  input  logic [DATA_W-1:0]   WD_DATA,
  // read-data stream
  output logic                RD_VALID,
  input  logic                RD_READY,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_LAST,
  // completion
  output logic                DONE,
  output logic                ERR,
  // AXI write address
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [3:0]          AWID,
  output logic [1:0]          AWBURST,
  output logic [2:0]          AWSIZE,
  output logic                AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic [3:0]          AWQOS,
  output logic                AWUSER,
  // AXI write data
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  output logic                WUSER,
  // AXI write response
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // AXI read address
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [3:0]          ARID,
  output logic [1:0]          ARBURST,
  output logic [2:0]          ARSIZE,
  output logic                ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic [3:0]          ARQOS,
  output logic                ARUSER,
  // AXI read data
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int         BYTES   = DATA_W / 8;
  localparam logic [7:0] LEN_MAX = 8'(MAX_BEATS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic                err_q;
  logic                awvalid_q;
  logic                arvalid_q;

  logic [7:0]          req_len_c;
  logic                bnd_err;
  logic                w_hs;
  logic                r_hs;
  logic                beat_last;
  logic [7:0]          beat_cnt;
  logic                done_c;
  logic                beat_err_c;

  assign req_len_c = (REQ_LEN > LEN_MAX) ? LEN_MAX : REQ_LEN;

`ifdef AXI_4K_CHECK_EN
  logic [31:0] end_off;
  assign end_off = 32'(REQ_ADDR[11:0]) + (32'(req_len_c) + 32'd1) * 32'(BYTES);
  assign bnd_err = (end_off > 32'd4096);
`else
  assign bnd_err = 1'b0;
`endif

  assign w_hs = (state_q == S_WDATA) && WD_VALID && WREADY;
  assign r_hs = (state_q == S_RDATA) && RVALID && RD_READY;

  axi_beat_counter u_beat_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (state_q == S_IDLE),
    .inc_i  (w_hs || r_hs),
    .len_i  (len_q),
    .cnt_o  (beat_cnt),
    .last_o (beat_last)
  );

  // Completion and per-cycle error detection, combinational with the
  // final B or R handshake so DONE lands in the handshake cycle.
  always_comb begin
    done_c     = 1'b0;
    beat_err_c = 1'b0;
    case (state_q)
      S_WRESP: begin
        done_c     = BVALID;
        beat_err_c = (BRESP != RESP_OKAY);
      end
      S_RDATA: begin
        if (r_hs) begin
          done_c     = beat_last;
          beat_err_c = (RRESP != RESP_OKAY) || (beat_last && !RLAST);
        end
      end
      S_BNDERR: begin
        done_c     = 1'b1;
        beat_err_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction sequencer with registered address-channel valids.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= 8'd0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (REQ_VALID) begin
            addr_q <= REQ_ADDR;
            len_q  <= req_len_c;
            err_q  <= 1'b0;
            if (bnd_err) begin
              state_q <= S_BNDERR;
            end else if (REQ_WE) begin
              state_q   <= S_WADDR;
              awvalid_q <= 1'b1;
            end else begin
              state_q   <= S_RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_WADDR: begin
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            state_q   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_hs && beat_last) begin
            state_q <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (BVALID) begin
            err_q   <= err_q || beat_err_c;
            state_q <= S_IDLE;
          end
        end
        S_RADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            err_q <= err_q || beat_err_c;
            if (beat_last) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_BNDERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          awvalid_q <= 1'b0;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign DONE      = done_c;
  assign ERR       = done_c && (err_q || beat_err_c);

  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWVALID = awvalid_q;
  assign AWID    = 4'd0;
  assign AWBURST = BURST_INCR;
  assign AWSIZE  = axsize(DATA_W);
  assign AWLOCK  = 1'b0;
  assign AWCACHE = CACHE_DEF;
  assign AWPROT  = 3'd0;
  assign AWQOS   = 4'd0;
  assign AWUSER  = 1'b0;

  // Write data is a straight pass-through while in the data phase.
  assign WVALID   = (state_q == S_WDATA) && WD_VALID;
  assign WD_READY = (state_q == S_WDATA) && WREADY;
  assign WDATA    = WD_DATA;
  assign WSTRB    = '1;
  assign WLAST    = (state_q == S_WDATA) && beat_last;
  assign WUSER    = 1'b0;

  assign BREADY = (state_q == S_WRESP);

  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARVALID = arvalid_q;
  assign ARID    = 4'd0;
  assign ARBURST = BURST_INCR;
  assign ARSIZE  = axsize(DATA_W);
  assign ARLOCK  = 1'b0;
  assign ARCACHE = CACHE_DEF;
  assign ARPROT  = 3'd0;
  assign ARQOS   = 4'd0;
  assign ARUSER  = 1'b0;

  // Read data is a straight pass-through; RD_LAST comes from the local count.
  assign RREADY   = (state_q == S_RDATA) && RD_READY;
  assign RD_VALID = (state_q == S_RDATA) && RVALID;
  assign RD_DATA  = RDATA;
  assign RD_LAST  = (state_q == S_RDATA) && beat_last;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master (DATA_W=32, MAX_BEATS=16). A phase-level
// model of the transaction checks the outputs every cycle; a literal table
// of per-transaction results pins the model. Honours AXI_4K_CHECK_EN.
module tb_axi_burst_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [7:0]  REQ_LEN;
  logic        WD_VALID, WD_READY;
  logic [31:0] WD_DATA;
  logic        RD_VALID, RD_READY, RD_LAST;
  logic [31:0] RD_DATA;
  logic        DONE, ERR;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [3:0]  AWID, ARID, AWCACHE, ARCACHE, AWQOS, ARQOS;
  logic [1:0]  AWBURST, ARBURST;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic        AWLOCK, ARLOCK, AWUSER, ARUSER, WUSER;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RLAST, RVALID, RREADY;

  always #5 CLK = ~CLK;

  axi_burst_master #(.ADDR_W(32), .DATA_W(32), .MAX_BEATS(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .DONE(DONE), .ERR(ERR),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWID(AWID), .AWBURST(AWBURST), .AWSIZE(AWSIZE), .AWLOCK(AWLOCK),
    .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS), .AWUSER(AWUSER),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .WUSER(WUSER),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARID(ARID), .ARBURST(ARBURST), .ARSIZE(ARSIZE), .ARLOCK(ARLOCK),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS), .ARUSER(ARUSER),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Hand-computed per-transaction results: AxLEN, beats moved, ERR.
  // Entry 5 is abandoned by reset and never completes.
`ifdef AXI_4K_CHECK_EN
  localparam int B7 = 0;
  localparam int E7 = 1;
`else
  localparam int B7 = 4;
  localparam int E7 = 0;
`endif
  localparam int LIT_LEN   [9] = '{3, 0, 7, 15, 7, 2, 3, 1, 1};
  localparam int LIT_BEATS [9] = '{4, 1, 8, 16, 0, 3, B7, 2, 2};
  localparam int LIT_ERR   [9] = '{0, 1, 0, 0, 0, 0, E7, 1, 1};

  int tests = 0;
  int fails = 0;
  int tmo_cnt = 0;
  logic fin_req = 1'b0;
  logic fin_ack = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Phase model: 0 idle, 1 write addr, 2 write data, 3 write resp,
  // 4 read addr, 5 read data, 6 refused (4KB crossing).
  initial begin : mon
    int          ph, m_len, m_beat, n_req, n_done, tmo_seen, beats;
    logic [31:0] m_addr;
    logic        m_err, whs, rhs, is_last, exp_done, berr;
    longint      end_off;
    ph = 0; m_len = 0; m_beat = 0; n_req = 0; n_done = 0; tmo_seen = 0;
    m_addr = '0; m_err = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        ph = 0;
      end else begin
        chk("timeout", tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
        whs     = (ph == 2) && WD_VALID && WREADY;
        rhs     = (ph == 5) && RVALID && RD_READY;
        is_last = (m_beat == m_len);

        chk("req_ready", REQ_READY, ph == 0);
        chk("awvalid", AWVALID, ph == 1);
        chk("arvalid", ARVALID, ph == 4);
        if (ph == 1) begin
          chk("awaddr", AWADDR, m_addr);
          chk("awlen", AWLEN, m_len);
        end
        if (ph == 4) begin
          chk("araddr", ARADDR, m_addr);
          chk("arlen", ARLEN, m_len);
        end
        chk("wvalid", WVALID, (ph == 2) && WD_VALID);
        chk("wd_ready", WD_READY, (ph == 2) && WREADY);
        chk("wlast", WLAST, (ph == 2) && is_last);
        if (whs) chk("wdata", WDATA, 32'hA500_0000 + 32'(m_beat));
        if (ph == 2) chk("wstrb", WSTRB, 4'hF);
        chk("bready", BREADY, ph == 3);
        chk("rready", RREADY, (ph == 5) && RD_READY);
        chk("rd_valid", RD_VALID, (ph == 5) && RVALID);
        chk("rd_last", RD_LAST, (ph == 5) && is_last);
        if (rhs) chk("rd_data", RD_DATA, 32'h5A00_0000 + 32'(m_beat));
        if (ph == 1) chk("aw_side", {AWID, AWBURST, AWSIZE, AWLOCK, AWCACHE, AWPROT, AWQOS, AWUSER},
                         {4'd0, 2'b01, 3'd2, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});
        if (ph == 4) chk("ar_side", {ARID, ARBURST, ARSIZE, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER},
                         {4'd0, 2'b01, 3'd2, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});

        exp_done = ((ph == 3) && BVALID) || (rhs && is_last) || (ph == 6);
        berr     = ((ph == 3) && (BRESP != 2'b00)) ||
                   (rhs && ((RRESP != 2'b00) || (is_last && !RLAST))) || (ph == 6);
        chk("done", DONE, exp_done);
        chk("err", ERR, exp_done && (m_err || berr));

        if (exp_done && DONE && n_req >= 1 && n_req <= 9) begin
          beats = (ph == 3) ? m_beat : (ph == 5) ? m_beat + 1 : 0;
          chk("lit_len", m_len, LIT_LEN[n_req-1]);
          chk("lit_beats", beats, LIT_BEATS[n_req-1]);
          chk("lit_err", ERR, LIT_ERR[n_req-1]);
          n_done = n_done + 1;
        end

        case (ph)
          0: if (REQ_VALID && REQ_READY) begin
               m_addr  = REQ_ADDR;
               m_len   = (REQ_LEN > 8'd15) ? 15 : int'(REQ_LEN);
               m_err   = 1'b0;
               m_beat  = 0;
               n_req   = n_req + 1;
               end_off = longint'(REQ_ADDR[11:0]) + (m_len + 1) * 4;
`ifdef AXI_4K_CHECK_EN
               if (end_off > 4096) ph = 6;
               else
`endif
               ph = REQ_WE ? 1 : 4;
             end
          1: if (AWREADY) ph = 2;
          2: if (whs) begin
               m_beat = m_beat + 1;
               if (is_last) ph = 3;
             end
          3: if (BVALID) ph = 0;
          4: if (ARREADY) ph = 5;
          5: if (rhs) begin
               m_err = m_err || berr;
               if (is_last) ph = 0;
               else m_beat = m_beat + 1;
             end
          default: ph = 0;
        endcase
      end
      if (fin_req && !fin_ack) begin
        chk("done_count", n_done, 8);
        fin_ack = 1'b1;
      end
    end
  end

  task automatic clear_inputs();
    REQ_VALID = 0; REQ_WE = 0; REQ_ADDR = '0; REQ_LEN = '0;
    WD_VALID = 0; WD_DATA = '0; RD_READY = 0;
    AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0; ARREADY = 0;
    RDATA = '0; RRESP = 0; RLAST = 0; RVALID = 0;
  endtask

  // One request plus a simple AXI slave. addr_dly delays AxREADY,
  // rst_at (>=0) pulses RST after that many W beats, no_rlast drops RLAST.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [7:0] len,
                         input int addr_dly, input logic [1:0] resp, input logic toggle,
                         input int rst_at, input logic no_rlast);
    int   cyc, wb, rb, elen;
    logic acc, ard, wd, fin, s_done, s_ar, s_w, s_r;
    elen = (len > 8'd15) ? 15 : int'(len);
    REQ_VALID = 1; REQ_WE = we; REQ_ADDR = addr; REQ_LEN = len;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge CLK); acc = REQ_READY;
      @(posedge CLK); #1;
    end
    REQ_VALID = 0;
    if (!acc) tmo_cnt = tmo_cnt + 1;
    cyc = 0; wb = 0; rb = 0; ard = 0; wd = 0; fin = !acc;
    while (!fin && cyc < 300) begin
      AWREADY  = (cyc >= addr_dly);
      ARREADY  = (cyc >= addr_dly);
      WD_VALID = !wd; WD_DATA = 32'hA500_0000 + 32'(wb); WREADY = 1;
      BVALID   = wd; BRESP = resp;
      RVALID   = ard && (rb <= elen); RDATA = 32'h5A00_0000 + 32'(rb);
      RLAST    = (rb == elen) && !no_rlast; RRESP = resp;
      RD_READY = toggle ? cyc[0] : 1'b1;
      @(negedge CLK);
      s_done = DONE; s_ar = ARVALID && ARREADY;
      s_w = WVALID && WREADY; s_r = RVALID && RREADY;
      @(posedge CLK); #1;
      cyc = cyc + 1;
      if (s_ar) ard = 1;
      if (s_w) begin
        wb = wb + 1;
        if (wb == elen + 1) wd = 1;
      end
      if (s_r) rb = rb + 1;
      if (s_done) fin = 1;
      if (!fin && rst_at >= 0 && wb == rst_at) begin
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(posedge CLK); #1;
        fin = 1;
      end
    end
    if (!fin) tmo_cnt = tmo_cnt + 1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RST = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(posedge CLK); #1;
    run_txn(1'b1, 32'h100, 8'd3,  2, 2'b00, 1'b0, -1, 1'b0);
    run_txn(1'b0, 32'h200, 8'd0,  0, 2'b10, 1'b0, -1, 1'b0);
    run_txn(1'b0, 32'h300, 8'd7,  0, 2'b00, 1'b1, -1, 1'b0);
    run_txn(1'b1, 32'h400, 8'd40, 0, 2'b00, 1'b0, -1, 1'b0);
    run_txn(1'b1, 32'h500, 8'd7,  0, 2'b00, 1'b0,  1, 1'b0);
    run_txn(1'b0, 32'h600, 8'd2,  1, 2'b00, 1'b0, -1, 1'b0);
    run_txn(1'b1, 32'hFF8, 8'd3,  0, 2'b00, 1'b0, -1, 1'b0);
    run_txn(1'b1, 32'h800, 8'd1,  0, 2'b11, 1'b0, -1, 1'b0);
    run_txn(1'b0, 32'h900, 8'd1,  0, 2'b00, 1'b0, -1, 1'b1);
    repeat (2) @(posedge CLK);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(posedge CLK);
    if (!fin_ack) begin
      fails = fails + 1;
      $display("FAIL final_check: got no ack expected ack");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Parametrised AXI4 master port, the successor to the fixed single-beat AXI configuration block.
- Converts a simple request/stream interface from the dataflow core into AXI4 INCR bursts of 1..MAX_BEATS beats.
- Drives all AXI4 channels, including the sideband constants, with data width parametrised.
- One outstanding transaction at a time: read or write.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width in bits; legal values 32, 64, 128. AxSIZE = log2(DATA_W/8).
MAX_BEATS, 16, largest burst; legal range 1..256. REQ_LEN above MAX_BEATS-1 is clamped.

Ports:
CLK  in  1  clock.
RST  in  1  reset; synchronous, active-high.
REQ_VALID  in  1  request valid.
REQ_READY  out  1  high only in IDLE.
REQ_WE  in  1  1 = write, 0 = read.
REQ_ADDR  in  ADDR_W  start address; must be DATA_W/8 aligned.
REQ_LEN  in  8  beats minus 1.
WD_VALID/WD_READY/WD_DATA  in/out/in  1/1/DATA_W  write-data stream.
RD_VALID/RD_READY/RD_DATA/RD_LAST  out/in/out/out  1/1/DATA_W/1  read-data stream.
DONE  out  1  one-cycle pulse when a transaction completes.
ERR  out  1  valid with DONE; set if any RRESP or BRESP is non-OKAY.
AWADDR/AWLEN/AWVALID/AWREADY  out/out/out/in  ADDR_W/8/1/1.
WDATA/WSTRB/WLAST/WVALID/WREADY  out/out/out/out/in  DATA_W/DATA_W/8/1/1/1.
BRESP/BVALID/BREADY  in/in/out  2/1/1.
ARADDR/ARLEN/ARVALID/ARREADY  out/out/out/in  ADDR_W/8/1/1.
RDATA/RRESP/RLAST/RVALID/RREADY  in/in/in/in/out  DATA_W/2/1/1/1.
AW*/AR* constants  out  as AXI4  ID=0, BURST=01 (INCR), SIZE=log2(DATA_W/8), LOCK=0, CACHE=0011, PROT=0, QOS=0, USER=0; WUSER=0.

Behaviour:
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- Reset: state IDLE. All VALID/READY outputs, DONE, ERR and RD_LAST are 0. Address, length and beat-count registers are 0.
- IDLE: REQ_READY=1. On REQ_VALID, latch addr, len = min(REQ_LEN, MAX_BEATS-1) and we. Clear the error flag. Go to WADDR if we=1, else RADDR.
- WADDR: AWVALID=1 from the registered request. Hold AWVALID and AWADDR stable until AWREADY, then go to WDATA.
- WDATA:
  - WVALID=WD_VALID and WD_READY=WREADY, combinational pass-through with no buffer.
  - WSTRB is all ones.
  - WLAST=1 when beat count == len.
  - Beat count increments on WVALID&&WREADY. The last-beat handshake goes to WRESP.
- WRESP: BREADY=1. On BVALID, set the error flag if BRESP!=00, pulse DONE, go to IDLE.
- RADDR: ARVALID held until ARREADY, then go to RDATA.
- RDATA:
  - RREADY=RD_READY, RD_VALID=RVALID, RD_DATA=RDATA.
  - RD_LAST=1 when beat count == len, counted locally.
  - Error flag is set on any accepted beat with RRESP!=00.
  - Mismatch between RLAST and the local count on the final beat sets the error flag.
  - The final beat pulses DONE and goes to IDLE.
- ERR equals the error flag while DONE=1; otherwise 0.
- Latency:
  - Request acceptance to AWVALID/ARVALID: 1 cycle.
  - Final B or R handshake to DONE: same cycle, combinational with the handshake.
  - DONE to next REQ_READY: 1 cycle.
- len=0 gives a single beat with WLAST/RD_LAST on the first beat.
- len=255 with MAX_BEATS=256 needs an 8-bit counter with no wrap before compare.
- Simultaneous REQ_VALID and DONE: the new request is not accepted until IDLE.
- RST mid-transaction returns to IDLE immediately. Any in-flight AXI transaction is abandoned; the system resets slave and master together.

Optional Feature:
- Macro: AXI_4K_CHECK_EN.
- With the macro: in IDLE, a request with (addr[11:0] + (len+1)*DATA_W/8) > 4096 is not issued. It completes with a one-cycle DONE and ERR=1 the cycle after acceptance, with no AXI traffic.
- Without the macro: requests are issued unchecked, and the caller guarantees no 4KB crossing.

Decomposition:
- Shared package axi_pkg holds:
  - FSM state enum.
  - AXI constants: BURST_INCR=2'b01, CACHE_DEF=4'b0011, RESP_OKAY=2'b00.
  - A function computing AxSIZE from DATA_W.
- One sub-module, axi_beat_counter: beat counter plus last-compare, shared by the WDATA and RDATA states.

Test Plan:
- Write, addr 0x100, REQ_LEN=3, AWREADY delayed 2 cycles, then WREADY always high.
  - Response: AWLEN=3 and AWADDR=0x100 held stable through the delay.
  - Four W beats, WLAST on the 4th.
  - BRESP=00 gives DONE with ERR=0.
- Read, REQ_LEN=0, RRESP=10 (SLVERR).
  - Response: ARLEN=0, one beat with RD_LAST=1, DONE with ERR=1.
- Read, REQ_LEN=7, with RD_READY toggling every other cycle.
  - Response: RREADY mirrors RD_READY.
  - Exactly 8 beats delivered in order, RD_LAST on the 8th.
- Write, REQ_LEN=40, MAX_BEATS=16.
  - Response: AWLEN=15, WLAST on beat 16, DONE.
- RST asserted during WDATA beat 2.
  - Response: next cycle all VALIDs=0, REQ_READY=1.
  - A following read completes normally.
- With AXI_4K_CHECK_EN: write at 0xFF8, REQ_LEN=3, DATA_W=32.
  - Response: no AWVALID; DONE with ERR=1.
  - Without the macro, AWVALID is issued.
